ping_pong_counter_gen: RTL and testbench

Parametrised ping-pong counter: the next generation of the lab-3 counter core. Counts between run-time `min`/`max` bounds in a configurable step, in either bounce (ping-pong) or wrap mode. Advances on a single-cycle `tick` strobe from the counting clock divider instead of a divided clock. Direction-flip requests between ticks are latched so none are lost. Sits between the debounce/onepulse front end and the seven-segment display driver, and exposes registered count, direction and an event pulse.

---
 rtl/ping_pong_counter_gen_if.sv | 27 ++
 rtl/ping_pong_counter_gen.sv | 95 +++++++++
 tb/tb_ping_pong_counter_gen.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ping_pong_counter_gen_if.sv
// Control/status bundle between the counter core and its front end / display driver.
interface ping_pong_counter_gen_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
);
  logic              tick;
  logic              enable;
  logic              flip;
  logic              mode;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  max;
  logic [WIDTH-1:0]  min;
  logic [WIDTH-1:0]  count;
  logic              dir;
  logic              event_p;
  logic              range_ok;

  modport master (
    output tick, enable, flip, mode, step, max, min,
    input  count, dir, event_p, range_ok
  );

  modport slave (
    input  tick, enable, flip, mode, step, max, min,
    output count, dir, event_p, range_ok
  );
endinterface

// File: rtl/ping_pong_counter_gen.sv
// Bounce/wrap counter advancing on tick; count/dir/event_p registered, 1 cycle after tick.
// No backpressure: every qualifying tick advances, flips between ticks are held in r_pend.
module ping_pong_counter_gen #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  ping_pong_counter_gen_if.slave   bus
);
  localparam int XW = WIDTH + 1;

  logic [WIDTH-1:0] r_count;
  logic             r_dir;
  logic             r_event;
  logic             r_pend;

  logic             w_range_ok;
  logic             w_adv;
  logic             w_d;
  logic [XW-1:0]    w_s;
  logic [XW-1:0]    w_cnt_x;
  logic [XW-1:0]    w_max_x;
  logic [XW-1:0]    w_min_x;
  logic [XW-1:0]    w_up_sum;
  logic [WIDTH-1:0] w_dn_diff;
  logic [WIDTH-1:0] w_up_sat;
  logic [WIDTH-1:0] w_dn_sat;
  logic             w_at_max;
  logic             w_at_min;

  assign w_range_ok = bus.max > bus.min;
  assign w_adv      = bus.tick && bus.enable && w_range_ok;
  // A flip in the same cycle as the tick is folded in directly.
  assign w_d        = r_dir ^ (r_pend | bus.flip);

  assign w_s       = (bus.step == '0) ? XW'(1) : XW'(bus.step);
  assign w_cnt_x   = XW'(r_count);
  assign w_max_x   = XW'(bus.max);
  assign w_min_x   = XW'(bus.min);
  assign w_up_sum  = w_cnt_x + w_s;
  assign w_dn_diff = r_count - w_s[WIDTH-1:0];
  assign w_up_sat  = (w_up_sum > w_max_x) ? bus.max : w_up_sum[WIDTH-1:0];
  // Borrow-free test: only subtract when the result stays at or above min.
  assign w_dn_sat  = (w_cnt_x >= w_min_x + w_s) ? w_dn_diff : bus.min;
  assign w_at_max  = r_count == bus.max;
  assign w_at_min  = r_count == bus.min;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= bus.min;
      r_dir   <= 1'b1;
      r_event <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      r_event <= 1'b0;
      if (w_adv) begin
        r_pend <= 1'b0;
        if (r_count > bus.max) begin
          r_count <= bus.max;
          r_dir   <= 1'b0;
        end else if (r_count < bus.min) begin
          r_count <= bus.min;
          r_dir   <= 1'b1;
        end else if (!bus.mode) begin
          if (w_d) begin
            r_count <= w_at_max ? w_dn_sat : w_up_sat;
            r_dir   <= !w_at_max;
            r_event <= w_at_max;
          end else begin
            r_count <= w_at_min ? w_up_sat : w_dn_sat;
            r_dir   <= w_at_min;
            r_event <= w_at_min;
          end
        end else begin
          r_dir <= w_d;
          if (w_d) begin
            r_count <= w_at_max ? bus.min : w_up_sat;
            r_event <= w_at_max;
          end else begin
            r_count <= w_at_min ? bus.max : w_dn_sat;
            r_event <= w_at_min;
          end
        end
      end else if (bus.flip) begin
        r_pend <= 1'b1;
      end
    end
  end

  assign bus.count    = r_count;
  assign bus.dir      = r_dir;
  assign bus.event_p  = r_event;
  assign bus.range_ok = w_range_ok;
endmodule

// File: tb/tb_ping_pong_counter_gen.sv
// Bench for ping_pong_counter_gen: directed scenarios plus randomized run against an integer model.
module tb_ping_pong_counter_gen;
  logic i_clk;
  logic i_rst_n;

  ping_pong_counter_gen_if #(.WIDTH(8), .STEP_W(4)) bus ();

  ping_pong_counter_gen #(.WIDTH(8), .STEP_W(4)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int vectors = 0;
  int errors  = 0;

  // Integer reference state
  int m_cnt  = 0;
  int m_dir  = 1;
  int m_pend = 0;
  int m_evt  = 0;

  // One clock with the given tick/flip; updates the reference model from pre-edge inputs.
  task automatic cyc(input bit t, input bit f);
    int c, d, p, e, s, ed, lo, hi;
    bus.tick = t;
    bus.flip = f;
    c = m_cnt; d = m_dir; p = m_pend; e = 0;
    lo = int'(bus.min); hi = int'(bus.max);
    if (!i_rst_n) begin
      c = lo; d = 1; p = 0;
    end else if (t && bus.enable && (hi > lo)) begin
      p = 0;
      if (c > hi) begin
        c = hi; d = 0;
      end else if (c < lo) begin
        c = lo; d = 1;
      end else begin
        s  = (bus.step == 0) ? 1 : int'(bus.step);
        ed = m_dir ^ (m_pend | int'(f));
        if (!bus.mode) begin
          if (ed == 1 && c == hi) begin
            c = (c - s < lo) ? lo : c - s; d = 0; e = 1;
          end else if (ed == 1) begin
            c = (c + s > hi) ? hi : c + s; d = 1;
          end else if (c == lo) begin
            c = (c + s > hi) ? hi : c + s; d = 1; e = 1;
          end else begin
            c = (c - s < lo) ? lo : c - s; d = 0;
          end
        end else begin
          d = ed;
          if (ed == 1) begin
            if (c == hi) begin c = lo; e = 1; end
            else c = (c + s > hi) ? hi : c + s;
          end else begin
            if (c == lo) begin c = hi; e = 1; end
            else c = (c - s < lo) ? lo : c - s;
          end
        end
      end
    end else if (f) begin
      p = 1;
    end
    @(posedge i_clk);
    #1;
    m_cnt = c; m_dir = d; m_pend = p; m_evt = e;
    bus.tick = 1'b0;
    bus.flip = 1'b0;
  endtask

  task automatic do_reset(input int lo, input int hi, input bit md, input int st);
    bus.min = 8'(lo); bus.max = 8'(hi); bus.mode = md; bus.step = 4'(st);
    bus.enable = 1'b1;
    i_rst_n = 1'b0;
    cyc(0, 0);
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.min = 8'd3; bus.max = 8'd7; bus.mode = 1'b0; bus.step = 4'd1; bus.enable = 1'b1;
    i_rst_n = 1'b0;
    cyc(1, 1);
    cyc(1, 0);
    i_rst_n = 1'b1;
    vectors++; if (bus.count !== 8'd3) begin errors++; $display("FAIL reset_count got %0d want 3", bus.count); end
    vectors++; if (bus.dir !== 1'b1) begin errors++; $display("FAIL reset_dir got %b want 1", bus.dir); end
    vectors++; if (bus.event_p !== 1'b0) begin errors++; $display("FAIL reset_event got %b want 0", bus.event_p); end
  endtask

  task automatic test_bounce_step1();
    int  exp_c[8] = '{1, 2, 3, 2, 1, 0, 1, 2};
    bit  exp_e[8] = '{0, 0, 0, 1, 0, 0, 1, 0};
    do_reset(0, 3, 0, 1);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0);
      vectors++; if (bus.count !== 8'(exp_c[i])) begin errors++; $display("FAIL bounce1_count[%0d] got %0d want %0d", i, bus.count, exp_c[i]); end
      vectors++; if (bus.event_p !== exp_e[i]) begin errors++; $display("FAIL bounce1_event[%0d] got %b want %b", i, bus.event_p, exp_e[i]); end
    end
  endtask

  task automatic test_bounce_step3();
    int  exp_c[8] = '{5, 8, 9, 6, 3, 2, 5, 8};
    bit  exp_e[8] = '{0, 0, 0, 1, 0, 0, 1, 0};
    do_reset(2, 9, 0, 3);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0);
      vectors++; if (bus.count !== 8'(exp_c[i])) begin errors++; $display("FAIL bounce3_count[%0d] got %0d want %0d", i, bus.count, exp_c[i]); end
      vectors++; if (bus.event_p !== exp_e[i]) begin errors++; $display("FAIL bounce3_event[%0d] got %b want %b", i, bus.event_p, exp_e[i]); end
    end
  endtask

  task automatic test_flip_latch();
    do_reset(0, 9, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, 0);
    cyc(0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0);
    cyc(0, 1);
    cyc(1, 0);
    vectors++; if (bus.count !== 8'd3) begin errors++; $display("FAIL flip_latch_count got %0d want 3", bus.count); end
    vectors++; if (bus.dir !== 1'b0) begin errors++; $display("FAIL flip_latch_dir got %b want 0", bus.dir); end
    do_reset(0, 9, 0, 1);
    for (int i = 0; i < 9; i++) cyc(1, 0);
    cyc(1, 1);
    vectors++; if (bus.count !== 8'd8) begin errors++; $display("FAIL flip_same_count got %0d want 8", bus.count); end
    vectors++; if (bus.event_p !== 1'b0) begin errors++; $display("FAIL flip_same_event got %b want 0", bus.event_p); end
    vectors++; if (bus.dir !== 1'b0) begin errors++; $display("FAIL flip_same_dir got %b want 0", bus.dir); end
  endtask

  task automatic test_wrap();
    int  exp_c[5] = '{2, 3, 4, 1, 2};
    bit  exp_e[5] = '{0, 0, 0, 1, 0};
    do_reset(1, 4, 1, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0);
      vectors++; if (bus.count !== 8'(exp_c[i])) begin errors++; $display("FAIL wrap_count[%0d] got %0d want %0d", i, bus.count, exp_c[i]); end
      vectors++; if (bus.event_p !== exp_e[i]) begin errors++; $display("FAIL wrap_event[%0d] got %b want %b", i, bus.event_p, exp_e[i]); end
    end
    cyc(1, 1);
    vectors++; if (bus.count !== 8'd1 || bus.dir !== 1'b0) begin errors++; $display("FAIL wrap_flip got %0d/%b want 1/0", bus.count, bus.dir); end
    cyc(1, 0);
    vectors++; if (bus.count !== 8'd4) begin errors++; $display("FAIL wrap_down_count got %0d want 4", bus.count); end
    vectors++; if (bus.event_p !== 1'b1) begin errors++; $display("FAIL wrap_down_event got %b want 1", bus.event_p); end
  endtask

  task automatic test_bounds_disable();
    do_reset(0, 9, 0, 1);
    for (int i = 0; i < 9; i++) cyc(1, 0);
    bus.max = 8'd5;
    cyc(1, 0);
    vectors++; if (bus.count !== 8'd5 || bus.dir !== 1'b0) begin errors++; $display("FAIL recover_max got %0d/%b want 5/0", bus.count, bus.dir); end
    vectors++; if (bus.event_p !== 1'b0) begin errors++; $display("FAIL recover_event got %b want 0", bus.event_p); end
    bus.min = 8'd5;
    for (int i = 0; i < 4; i++) cyc(1, 0);
    vectors++; if (bus.count !== 8'd5 || bus.dir !== 1'b0) begin errors++; $display("FAIL range_hold got %0d/%b want 5/0", bus.count, bus.dir); end
    vectors++; if (bus.range_ok !== 1'b0) begin errors++; $display("FAIL range_ok_low got %b want 0", bus.range_ok); end
    bus.min = 8'd0; bus.max = 8'd9; bus.enable = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1, 0);
    vectors++; if (bus.count !== 8'd5 || bus.dir !== 1'b0) begin errors++; $display("FAIL disable_hold got %0d/%b want 5/0", bus.count, bus.dir); end
    vectors++; if (bus.range_ok !== 1'b1) begin errors++; $display("FAIL range_ok_high got %b want 1", bus.range_ok); end
    bus.enable = 1'b1;
  endtask

  task automatic test_random();
    do_reset(0, 20, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) bus.min = 8'($urandom_range(0, 40));
      if ($urandom_range(0, 19) == 0) bus.max = 8'($urandom_range(0, 40));
      if ($urandom_range(0, 29) == 0) bus.mode = ~bus.mode;
      if ($urandom_range(0, 99) == 0) bus.max = 8'($urandom_range(200, 255));
      bus.step   = 4'($urandom);
      bus.enable = ($urandom_range(0, 9) != 0);
      i_rst_n    = ($urandom_range(0, 149) != 0);
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 6) == 0);
      vectors++;
      if (bus.count !== 8'(m_cnt) || bus.dir !== 1'(m_dir) || bus.event_p !== 1'(m_evt)
          || bus.range_ok !== (bus.max > bus.min)) begin
        errors++;
        $display("FAIL random[%0d] got cnt=%0d dir=%b evt=%b rok=%b want cnt=%0d dir=%0d evt=%0d rok=%b",
                 i, bus.count, bus.dir, bus.event_p, bus.range_ok, m_cnt, m_dir, m_evt, bus.max > bus.min);
      end
    end
    i_rst_n = 1'b1;
  endtask

  initial begin
    i_rst_n = 1'b0;
    bus.tick = 1'b0; bus.flip = 1'b0; bus.enable = 1'b1; bus.mode = 1'b0;
    bus.step = 4'd1; bus.min = 8'd0; bus.max = 8'd0;
    test_reset();
    test_bounce_step1();
    test_bounce_step3();
    test_flip_latch();
    test_wrap();
    test_bounds_disable();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
